// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t;

endpackage

// File: rtl/full_adder_cell.sv
// Combinational full adder built from two half adders and an OR for the carry.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0, c0, c1;

  half_adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

  assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Combinational half adder: s = a ^ b, c = a & b.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder cell, start/busy/done handshake.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  sa_state_t        state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             carry;
  logic [CNT_W-1:0] count;
  logic             last_bit;
  logic             fa_s, fa_c;

  full_adder_cell u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .s   (fa_s),
    .cout(fa_c)
  );

  assign last_bit = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) state_next = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // sum fills from the MSB side, so after WIDTH shifts bit 0 holds the first-computed LSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            count <= '0;
          end
        end
        SHIFT: begin
          sum   <= {fa_s, sum[WIDTH-1:1]};
          carry <= fa_c;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          count <= count + 1'b1;
          if (last_bit) begin
            cout <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            ovf  <= carry ^ fa_c;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: cycle-level reference model plus directed and random operations.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: phase 0 = idle, 1..W = adding, W+1 = result cycle.
  int           phase = 0;
  logic [W:0]   exp_res = '0;
  logic         exp_ovf = 1'b0;
  logic [W:0]   nxt_res;
  logic         nxt_ovf;

  assign nxt_res = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign nxt_ovf = (a[W-1] == b[W-1]) && (nxt_res[W-1] != a[W-1]);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= 0;
      exp_res <= '0;
      exp_ovf <= 1'b0;
    end else if (phase == 0) begin
      if (start) begin
        phase   <= 1;
        exp_res <= nxt_res;
        exp_ovf <= nxt_ovf;
      end
    end else if (phase == W + 1) begin
      phase <= 0;
    end else begin
      phase <= phase + 1;
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'((phase >= 1) && (phase <= W)));
    chk("done", 32'(done), 32'(phase == W + 1));
    if (phase == 0 || phase == W + 1) begin
      chk("sum", 32'(sum), 32'(exp_res[W-1:0]));
      chk("cout", 32'(cout), 32'(exp_res[W]));
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf", 32'(ovf), 32'(exp_ovf));
`endif
    end
    if (done) done_seen++;
  end

  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                    output logic [W:0] r, output int lat);
    @(posedge clk);
    #2;
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 4 * W) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = {cout, sum};
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [W:0] r;
    int lat;
    int d0;
    logic [W-1:0] ra, rb;
    logic rc;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    #2 rst_n = 1'b1;

    op(8'h00, 8'h00, 1'b0, r, lat);
    chk("t1_latency", 32'(lat), W);
    chk("t1_res", 32'(r), 32'h000);

    op(8'hFF, 8'h01, 1'b0, r, lat);
    chk("t2a_res", 32'(r), 32'h100);
    op(8'hFF, 8'h00, 1'b1, r, lat);
    chk("t2b_res", 32'(r), 32'h100);

    op(8'h7F, 8'h01, 1'b0, r, lat);
    chk("t3a_res", 32'(r), 32'h080);
`ifdef SERIAL_ADDER_OVF_EN
    chk("t3a_ovf", 32'(ovf), 1);
`endif
    op(8'h80, 8'h80, 1'b0, r, lat);
    chk("t3b_res", 32'(r), 32'h100);
`ifdef SERIAL_ADDER_OVF_EN
    chk("t3b_ovf", 32'(ovf), 1);
`endif

    // start held high through SHIFT and DONE with a changed operand
    @(posedge clk);
    #2;
    d0 = done_seen;
    a = 8'h3C; b = 8'h0F; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #2;
    a = 8'h55; b = 8'h55;
    repeat (W + 1) @(posedge clk);
    #2;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t4_done_count", 32'(done_seen - d0), 1);
    chk("t4_res", 32'({cout, sum}), 32'h04B);

    // reset in the 4th adding cycle
    @(posedge clk);
    #2;
    d0 = done_seen;
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_sum", 32'(sum), 0);
    chk("t5_cout", 32'(cout), 0);
    #3;
    rst_n = 1'b1;
    repeat (2 * W + 4) @(posedge clk);
    #1;
    chk("t5_no_done", 32'(done_seen - d0), 0);

    // back-to-back then random sweep
    op(8'hA5, 8'h5A, 1'b1, r, lat);
    chk("t6a_res", 32'(r), 32'h100);
    op(8'h12, 8'h34, 1'b1, r, lat);
    chk("t6b_res", 32'(r), 32'h047);
    chk("t6b_latency", 32'(lat), W);

    for (int i = 0; i < 300; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      op(ra, rb, rc, r, lat);
      chk("rand_res", 32'(r), 32'(ra) + 32'(rb) + 32'(rc));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
